// File: rtl/cpu_defs.sv
// Shared RV32I core definitions: word types, op classes, op enum.
// Imported by every pipeline stage and the branch predictor.
package cpu_defs;

  localparam logic TRUE  = 1'b1;
  localparam logic FALSE = 1'b0;

  typedef logic [31:0] ADDR_TYPE;
  typedef logic [31:0] INST_TYPE;
  typedef logic [3:0]  OP_TYPE;
  typedef logic [5:0]  OPENUM_TYPE;

  localparam OP_TYPE OP_NONE  = 4'd0;
  localparam OP_TYPE OP_RC    = 4'd1;
  localparam OP_TYPE OP_RI    = 4'd2;
  localparam OP_TYPE OP_LD    = 4'd3;
  localparam OP_TYPE OP_ST    = 4'd4;
  localparam OP_TYPE OP_BR    = 4'd5;
  localparam OP_TYPE OP_LUI   = 4'd6;
  localparam OP_TYPE OP_AUIPC = 4'd7;
  localparam OP_TYPE OP_JAL   = 4'd8;
  localparam OP_TYPE OP_JALR  = 4'd9;

  localparam logic [6:0] OPC_LUI   = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC = 7'b0010111;
  localparam logic [6:0] OPC_JAL   = 7'b1101111;
  localparam logic [6:0] OPC_JALR  = 7'b1100111;
  localparam logic [6:0] OPC_BR    = 7'b1100011;
  localparam logic [6:0] OPC_LD    = 7'b0000011;
  localparam logic [6:0] OPC_ST    = 7'b0100011;
  localparam logic [6:0] OPC_RI    = 7'b0010011;
  localparam logic [6:0] OPC_RC    = 7'b0110011;

  typedef enum logic [5:0] {
    OPENUM_NOP,
    OPENUM_LUI, OPENUM_AUIPC, OPENUM_JAL, OPENUM_JALR,
    OPENUM_BEQ, OPENUM_BNE, OPENUM_BLT,
    OPENUM_BGE, OPENUM_BLTU, OPENUM_BGEU,
    OPENUM_LB, OPENUM_LH, OPENUM_LW,
    OPENUM_LBU, OPENUM_LHU,
    OPENUM_SB, OPENUM_SH, OPENUM_SW,
    OPENUM_ADDI, OPENUM_SLTI, OPENUM_SLTIU,
    OPENUM_XORI, OPENUM_ORI, OPENUM_ANDI,
    OPENUM_SLLI, OPENUM_SRLI, OPENUM_SRAI,
    OPENUM_ADD, OPENUM_SUB, OPENUM_SLL,
    OPENUM_SLT, OPENUM_SLTU, OPENUM_XOR,
    OPENUM_SRL, OPENUM_SRA, OPENUM_OR,
    OPENUM_AND
  } openum_e;

  typedef struct packed {
    ADDR_TYPE   pc;
    INST_TYPE   inst;
    OP_TYPE     op_type;
    OPENUM_TYPE op;
  } fifo_ent_t;

endpackage

// File: rtl/inst_predecode.sv
// Combinational RV32I predecode: class, exact op, JAL detect and offset.
// Shared between the fetch stage and the branch predictor.
module inst_predecode
  import cpu_defs::*;
(
  input  logic [31:0] inst,
  output logic [3:0]  op_type,
  output logic [5:0]  op,
  output logic        is_jal,
  output logic [31:0] jimm
);

  logic [6:0] opc;
  logic [2:0] f3;
  logic       f7b;
  logic       unused_rd;

  assign opc       = inst[6:0];
  assign f3        = inst[14:12];
  assign f7b       = inst[30];
  assign unused_rd = ^inst[11:7];

  assign is_jal = (opc == OPC_JAL);
  assign jimm   = {{11{inst[31]}}, inst[31],
                   inst[19:12], inst[20],
                   inst[30:21], 1'b0};

  always_comb begin
    op_type = OP_NONE;
    unique case (1'b1)
      (opc == OPC_RC):    op_type = OP_RC;
      (opc == OPC_RI):    op_type = OP_RI;
      (opc == OPC_BR):    op_type = OP_BR;
      (opc == OPC_LD):    op_type = OP_LD;
      (opc == OPC_ST):    op_type = OP_ST;
      (opc == OPC_LUI):   op_type = OP_LUI;
      (opc == OPC_AUIPC): op_type = OP_AUIPC;
      (opc == OPC_JAL):   op_type = OP_JAL;
      (opc == OPC_JALR):  op_type = OP_JALR;
      default:            op_type = OP_NONE;
    endcase
  end

  always_comb begin
    op = OPENUM_NOP;
    case (opc)
      OPC_LUI:   op = OPENUM_LUI;
      OPC_AUIPC: op = OPENUM_AUIPC;
      OPC_JAL:   op = OPENUM_JAL;
      OPC_JALR:  if (f3 == 3'd0) op = OPENUM_JALR;
      OPC_BR: case (f3)
        3'd0: op = OPENUM_BEQ;
        3'd1: op = OPENUM_BNE;
        3'd4: op = OPENUM_BLT;
        3'd5: op = OPENUM_BGE;
        3'd6: op = OPENUM_BLTU;
        3'd7: op = OPENUM_BGEU;
        default: op = OPENUM_NOP;
      endcase
      OPC_LD: case (f3)
        3'd0: op = OPENUM_LB;
        3'd1: op = OPENUM_LH;
        3'd2: op = OPENUM_LW;
        3'd4: op = OPENUM_LBU;
        3'd5: op = OPENUM_LHU;
        default: op = OPENUM_NOP;
      endcase
      OPC_ST: case (f3)
        3'd0: op = OPENUM_SB;
        3'd1: op = OPENUM_SH;
        3'd2: op = OPENUM_SW;
        default: op = OPENUM_NOP;
      endcase
      OPC_RI: case (f3)
        3'd0: op = OPENUM_ADDI;
        3'd1: op = OPENUM_SLLI;
        3'd2: op = OPENUM_SLTI;
        3'd3: op = OPENUM_SLTIU;
        3'd4: op = OPENUM_XORI;
        3'd5: op = f7b ? OPENUM_SRAI : OPENUM_SRLI;
        3'd6: op = OPENUM_ORI;
        default: op = OPENUM_ANDI;
      endcase
      // only ADD/SUB and SRL/SRA use funct7[5]; elsewhere it must be 0
      OPC_RC: case (f3)
        3'd0: op = f7b ? OPENUM_SUB : OPENUM_ADD;
        3'd5: op = f7b ? OPENUM_SRA : OPENUM_SRL;
        3'd1: if (!f7b) op = OPENUM_SLL;
        3'd2: if (!f7b) op = OPENUM_SLT;
        3'd3: if (!f7b) op = OPENUM_SLTU;
        3'd4: if (!f7b) op = OPENUM_XOR;
        3'd6: if (!f7b) op = OPENUM_OR;
        default: if (!f7b) op = OPENUM_AND;
      endcase
      default: op = OPENUM_NOP;
    endcase
  end

endmodule

// File: rtl/inst_fetcher.sv
// Fetch stage: PC, single outstanding memory request, predecoded FIFO.
// Redirects on JAL and on commit flush.
module inst_fetcher
  import cpu_defs::*;
#(
  parameter int          QUEUE_DEPTH = 4,
  parameter logic [31:0] RESET_PC    = 32'h0
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        rdy_in,
  output logic        if_to_mem_req,
  output logic [31:0] if_to_mem_addr,
  input  logic        mem_to_if_valid,
  input  logic [31:0] mem_to_if_inst,
  input  logic        stall_in,
  input  logic        flush_in,
  input  logic [31:0] flush_PC,
  output logic        if_to_dc_ready,
  output logic [31:0] if_to_dc_PC,
  output logic [31:0] if_to_dc_inst,
  output logic [3:0]  if_to_dc_opType,
  output logic [5:0]  if_to_dc_op
);

  localparam int PW = $clog2(QUEUE_DEPTH);
  localparam logic [PW:0] DEPTH_C = (PW+1)'(QUEUE_DEPTH);

  typedef enum logic [1:0] {IDLE, WAIT, DISCARD} state_e;

  state_e    state;
  ADDR_TYPE  fetch_pc;
  fifo_ent_t fifo_q [QUEUE_DEPTH];
  logic [PW-1:0] head;
  logic [PW-1:0] tail;
  logic [PW:0]   count;

  logic       empty;
  logic       has_space;
  logic       push;
  logic       pop;
  fifo_ent_t  head_ent;
  OP_TYPE     pd_op_type;
  OPENUM_TYPE pd_op;
  logic       pd_is_jal;
  ADDR_TYPE   pd_jimm;

  inst_predecode u_pd (
    .inst    (mem_to_if_inst),
    .op_type (pd_op_type),
    .op      (pd_op),
    .is_jal  (pd_is_jal),
    .jimm    (pd_jimm)
  );

  assign empty     = (count == '0);
  assign has_space = (count < DEPTH_C);
  assign push      = rdy_in && (state == WAIT)
                   && mem_to_if_valid && !flush_in;
  assign pop       = if_to_dc_ready;

  assign if_to_dc_ready = !empty && !stall_in
                        && rdy_in && !flush_in;
  assign head_ent       = empty ? '0 : fifo_q[head];
  assign if_to_dc_PC     = head_ent.pc;
  assign if_to_dc_inst   = head_ent.inst;
  assign if_to_dc_opType = head_ent.op_type;
  assign if_to_dc_op     = head_ent.op;

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state          <= IDLE;
      fetch_pc       <= RESET_PC;
      if_to_mem_req  <= FALSE;
      if_to_mem_addr <= '0;
    end else if (rdy_in) begin
      unique case (state)
        IDLE: begin
          if (flush_in) begin
            fetch_pc <= flush_PC;
          end else if (has_space) begin
            if_to_mem_req  <= TRUE;
            if_to_mem_addr <= fetch_pc;
            state          <= WAIT;
          end
        end
        WAIT: begin
          if (flush_in) begin
            fetch_pc <= flush_PC;
            if (mem_to_if_valid) begin
              if_to_mem_req <= FALSE;
              state         <= IDLE;
            end else begin
              state <= DISCARD;
            end
          end else if (mem_to_if_valid) begin
            if_to_mem_req <= FALSE;
            state         <= IDLE;
            fetch_pc      <= fetch_pc
                           + (pd_is_jal ? pd_jimm : 32'd4);
          end
        end
        // the stale request must complete before a new one may issue
        DISCARD: begin
          if (flush_in) fetch_pc <= flush_PC;
          if (mem_to_if_valid) begin
            if_to_mem_req <= FALSE;
            state         <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
      for (int i = 0; i < QUEUE_DEPTH; i++)
        fifo_q[i] <= '0;
    end else if (rdy_in) begin
      if (flush_in) begin
        head  <= '0;
        tail  <= '0;
        count <= '0;
      end else begin
        if (push) begin
          fifo_q[tail] <= '{pc:      fetch_pc,
                            inst:    mem_to_if_inst,
                            op_type: pd_op_type,
                            op:      pd_op};
          tail <= tail + PW'(1);
        end
        if (pop) head <= head + PW'(1);
        if (push && !pop)
          count <= count + (PW+1)'(1);
        else if (pop && !push)
          count <= count - (PW+1)'(1);
      end
    end
  end

endmodule

// File: tb/tb_inst_fetcher.sv
// Randomized bench for inst_fetcher with a queue-based fetch model.
// Directed reset/JAL/backpressure/flush cases precede a random run.
module tb_inst_fetcher;
  import cpu_defs::*;

  localparam int QD = 4;

  logic        clk, rst_n, rdy;
  logic        req, mvalid, stall, flush;
  logic [31:0] addr, minst, flush_pc;
  logic        dc_ready;
  logic [31:0] dc_pc, dc_inst;
  logic [3:0]  dc_optype;
  logic [5:0]  dc_op;

  inst_fetcher #(.QUEUE_DEPTH(QD), .RESET_PC(32'h0)) dut (
    .clk_in(clk), .rst_in(rst_n), .rdy_in(rdy),
    .if_to_mem_req(req), .if_to_mem_addr(addr),
    .mem_to_if_valid(mvalid), .mem_to_if_inst(minst),
    .stall_in(stall), .flush_in(flush), .flush_PC(flush_pc),
    .if_to_dc_ready(dc_ready), .if_to_dc_PC(dc_pc),
    .if_to_dc_inst(dc_inst), .if_to_dc_opType(dc_optype),
    .if_to_dc_op(dc_op)
  );

  initial clk = 0;
  always #5 clk = ~clk;

  typedef struct {
    logic [6:0] opc; int f3; int f7;
    OPENUM_TYPE op; OP_TYPE cls;
  } dec_t;

  dec_t tab [37] = '{
    '{7'h37,-1,-1,OPENUM_LUI,OP_LUI},
    '{7'h17,-1,-1,OPENUM_AUIPC,OP_AUIPC},
    '{7'h6F,-1,-1,OPENUM_JAL,OP_JAL},
    '{7'h67,0,-1,OPENUM_JALR,OP_JALR},
    '{7'h63,0,-1,OPENUM_BEQ,OP_BR},
    '{7'h63,1,-1,OPENUM_BNE,OP_BR},
    '{7'h63,4,-1,OPENUM_BLT,OP_BR},
    '{7'h63,5,-1,OPENUM_BGE,OP_BR},
    '{7'h63,6,-1,OPENUM_BLTU,OP_BR},
    '{7'h63,7,-1,OPENUM_BGEU,OP_BR},
    '{7'h03,0,-1,OPENUM_LB,OP_LD},
    '{7'h03,1,-1,OPENUM_LH,OP_LD},
    '{7'h03,2,-1,OPENUM_LW,OP_LD},
    '{7'h03,4,-1,OPENUM_LBU,OP_LD},
    '{7'h03,5,-1,OPENUM_LHU,OP_LD},
    '{7'h23,0,-1,OPENUM_SB,OP_ST},
    '{7'h23,1,-1,OPENUM_SH,OP_ST},
    '{7'h23,2,-1,OPENUM_SW,OP_ST},
    '{7'h13,0,-1,OPENUM_ADDI,OP_RI},
    '{7'h13,2,-1,OPENUM_SLTI,OP_RI},
    '{7'h13,3,-1,OPENUM_SLTIU,OP_RI},
    '{7'h13,4,-1,OPENUM_XORI,OP_RI},
    '{7'h13,6,-1,OPENUM_ORI,OP_RI},
    '{7'h13,7,-1,OPENUM_ANDI,OP_RI},
    '{7'h13,1,-1,OPENUM_SLLI,OP_RI},
    '{7'h13,5,0,OPENUM_SRLI,OP_RI},
    '{7'h13,5,1,OPENUM_SRAI,OP_RI},
    '{7'h33,0,0,OPENUM_ADD,OP_RC},
    '{7'h33,0,1,OPENUM_SUB,OP_RC},
    '{7'h33,1,0,OPENUM_SLL,OP_RC},
    '{7'h33,2,0,OPENUM_SLT,OP_RC},
    '{7'h33,3,0,OPENUM_SLTU,OP_RC},
    '{7'h33,4,0,OPENUM_XOR,OP_RC},
    '{7'h33,5,0,OPENUM_SRL,OP_RC},
    '{7'h33,5,1,OPENUM_SRA,OP_RC},
    '{7'h33,6,0,OPENUM_OR,OP_RC},
    '{7'h33,7,0,OPENUM_AND,OP_RC}
  };

  logic [6:0] opcs [10] = '{7'h37, 7'h17, 7'h6F, 7'h67,
    7'h63, 7'h03, 7'h23, 7'h13, 7'h33, 7'h0B};

  typedef struct { logic [31:0] pc; logic [31:0] inst; } ent_t;

  ent_t        q [$];
  ent_t        pop_log [$];
  logic [31:0] req_log [$];
  logic [31:0] mem [256];

  int checks = 0, errors = 0;
  int cyc = 0, pushes = 0;
  int first_push = -1, first_dut_ready = -1;
  int p_stall = 0, p_flush = 0, p_rdylow = 0;
  int lat_fixed = 1, lat_cnt = 0;
  bit busy = 0, discard = 0;
  bit f_force = 0, f_on_valid = 0;
  logic [31:0] f_pc = 0;
  logic [31:0] exp_pc = 0;
  bit c_rdy = 0, c_valid = 0, c_flush = 0;
  bit c_req = 0, c_ready = 0;
  logic [31:0] c_inst = 0, c_fpc = 0;
  int prev_size = 0;
  bit prev_req = 0;
  logic [31:0] prev_addr = 0;

  function automatic void chk(string nm, logic [31:0] act,
                              logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%h want=%h t=%0t", nm, act, exp, $time);
    end
  endfunction

  function automatic void mdec(input logic [31:0] i,
                               output OP_TYPE cls,
                               output OPENUM_TYPE op);
    bit hit = 0;
    cls = OP_NONE;
    op  = OPENUM_NOP;
    foreach (tab[k]) begin
      if (tab[k].opc == i[6:0]) begin
        cls = tab[k].cls;
        if (!hit && (tab[k].f3 < 0 || tab[k].f3 == int'(i[14:12]))
            && (tab[k].f7 < 0 || tab[k].f7 == int'(i[30]))) begin
          op  = tab[k].op;
          hit = 1;
        end
      end
    end
  endfunction

  function automatic logic [31:0] next_off(logic [31:0] i);
    int imm;
    if (i[6:0] != 7'b1101111) return 32'd4;
    imm = (int'(i[30:21]) << 1) + (int'(i[20]) << 11)
        + (int'(i[19:12]) << 12);
    if (i[31]) imm = imm - (1 << 20);
    return imm;
  endfunction

  function automatic logic [31:0] enc_jal(int off);
    logic [20:0] o;
    o = off[20:0];
    return {o[20], o[10:1], o[11], o[19:12], 5'd0, 7'h6F};
  endfunction

  task automatic step();
    OP_TYPE ec;
    OPENUM_TYPE eo;
    logic erdy;
    ent_t e;
    @(posedge clk);
    #1;
    cyc++;
    if (c_rdy) begin
      if (c_ready) void'(q.pop_front());
      if (c_valid) begin
        if (!c_flush && !discard) begin
          e.pc = exp_pc;
          e.inst = c_inst;
          q.push_back(e);
          exp_pc = exp_pc + next_off(c_inst);
          pushes++;
          if (first_push < 0) first_push = cyc;
        end
        discard = 0;
      end
      if (c_flush) begin
        q.delete();
        exp_pc = c_fpc;
        if (c_req && !c_valid) discard = 1;
      end
    end
    stall = ($urandom_range(99) < p_stall);
    rdy = !($urandom_range(99) < p_rdylow);
    flush = ($urandom_range(99) < p_flush);
    flush_pc = $urandom & 32'hFFFF_FFFC;
    if (f_force) begin
      flush = 1; flush_pc = f_pc; rdy = 1; f_force = 0;
    end
    mvalid = 0;
    if (!req) busy = 0;
    else if (rdy) begin
      if (!busy) begin
        busy = 1;
        lat_cnt = (lat_fixed >= 0) ? lat_fixed
                                   : int'($urandom_range(0, 3));
      end
      if (lat_cnt == 0) begin
        mvalid = 1; minst = mem[addr[9:2]]; busy = 0;
      end else lat_cnt--;
    end
    if (f_on_valid && mvalid) begin
      flush = 1; flush_pc = f_pc; f_on_valid = 0;
    end
    @(negedge clk);
    erdy = (q.size() > 0) && !stall && rdy && !flush;
    chk("ready", dc_ready, erdy);
    if (q.size() > 0) begin
      mdec(q[0].inst, ec, eo);
      chk("dc_pc", dc_pc, q[0].pc);
      chk("dc_inst", dc_inst, q[0].inst);
      chk("dc_optype", dc_optype, ec);
      chk("dc_op", dc_op, eo);
    end else begin
      chk("dc_zero", {dc_pc ^ dc_inst, dc_optype, dc_op} != 0, 0);
    end
    if (dc_ready && first_dut_ready < 0) first_dut_ready = cyc;
    if (erdy) pop_log.push_back(q[0]);
    if (req && !prev_req) begin
      chk("req_addr", addr, exp_pc);
      chk("req_space", prev_size < QD, 1);
      req_log.push_back(addr);
    end
    if (req && prev_req) chk("addr_hold", addr, prev_addr);
    c_rdy = rdy; c_valid = mvalid; c_flush = flush;
    c_req = req; c_ready = erdy;
    c_inst = minst; c_fpc = flush_pc;
    prev_size = q.size(); prev_req = req; prev_addr = addr;
  endtask

  task automatic wait_req(string nm, logic [31:0] want);
    int n0 = req_log.size();
    for (int k = 0; k < 60 && req_log.size() == n0; k++) step();
    chk({nm, "_timeout"}, req_log.size() > n0, 1);
    if (req_log.size() > n0) chk(nm, req_log[$], want);
    chk({nm, "_empty"}, q.size(), 0);
  endtask

  initial begin
    OP_TYPE tc;
    OPENUM_TYPE to;
    logic [31:0] w;
    int sel;
    for (int k = 0; k < 256; k++) begin
      w = $urandom;
      sel = $urandom_range(0, 10);
      if (sel < 10) w[6:0] = opcs[sel];
      if (w[6:0] == 7'h6F)
        w = enc_jal((int'($urandom_range(0, 63)) - 32) * 4);
      mem[k] = w;
    end
    mem[0] = 32'h00500093;
    mem[1] = 32'h00000013;
    mem[2] = 32'h0100006F;
    mem[6] = 32'h00000013;

    mdec(32'h00500093, tc, to);
    chk("model_addi_type", tc, OP_RI);
    chk("model_addi_op", to, OPENUM_ADDI);
    mdec(32'h40B50533, tc, to);
    chk("model_sub_op", to, OPENUM_SUB);
    chk("model_jimm", next_off(32'h0100006F), 32'd16);

    rst_n = 0; rdy = 1; stall = 0; flush = 0;
    flush_pc = 0; mvalid = 0; minst = 0;
    repeat (3) @(negedge clk);
    chk("rst_req", req, 0);
    chk("rst_addr", addr, 0);
    chk("rst_ready", dc_ready, 0);
    chk("rst_pc", dc_pc, 0);
    rst_n = 1;

    repeat (20) step();
    chk("seq_reqs", req_log.size() >= 4, 1);
    if (req_log.size() >= 4) begin
      chk("seq_a0", req_log[0], 32'h0);
      chk("seq_a1", req_log[1], 32'h4);
      chk("seq_a2", req_log[2], 32'h8);
      chk("jal_a3", req_log[3], 32'd24);
    end
    chk("first_ready_lat", first_dut_ready, first_push);
    chk("seq_pops", pop_log.size() >= 3, 1);
    if (pop_log.size() >= 3) begin
      chk("pop0_pc", pop_log[0].pc, 32'h0);
      chk("pop0_inst", pop_log[0].inst, 32'h00500093);
      chk("jal_pc", pop_log[2].pc, 32'h8);
    end

    p_stall = 100;
    repeat (40) step();
    chk("bp_full", q.size(), QD);
    chk("bp_req_low", req, 0);
    p_stall = 0;
    for (int k = 0; k < 4; k++) begin
      step();
      chk("bp_drain", dc_ready, 1);
    end

    lat_fixed = 4;
    for (int k = 0; k < 60 && !(req && busy && lat_cnt == 3); k++)
      step();
    chk("fl_arm", req && busy && lat_cnt == 3, 1);
    f_force = 1; f_pc = 32'h100;
    step();
    wait_req("fl_addr", 32'h100);

    lat_fixed = 2;
    f_on_valid = 1; f_pc = 32'h200;
    for (int k = 0; k < 60 && f_on_valid; k++) step();
    chk("fv_hit", f_on_valid, 0);
    wait_req("fv_addr", 32'h200);

    lat_fixed = -1;
    p_stall = 30; p_flush = 4; p_rdylow = 10;
    repeat (3000) step();
    chk("progress", pushes > 100, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/inst_fetcher.md
# inst_fetcher

Fetch stage of the out-of-order RV32I core. Holds the program counter, issues one instruction-word request at a time to the memory controller, and buffers returned words in a small FIFO. It pre-classifies each word into an op type and an op enum, then presents the FIFO head to the decoder over the `if_to_dc_*` interface. It redirects on JAL, and on a flush from commit.

## Interface
- `QUEUE_DEPTH`, 4: instruction FIFO entries; must be a power of two and at least 2.
- `RESET_PC`, 32'h0: PC loaded at reset.

- `clk_in`  in  1  clock.
- `rst_in`  in  1  asynchronous, active-low reset.
- `rdy_in`  in  1  global enable; when low, every register holds.
- `if_to_mem_req`  out  1  fetch request, held until `mem_to_if_valid`.
- `if_to_mem_addr`  out  32  word address of the request; stable while `if_to_mem_req` is high.
- `mem_to_if_valid`  in  1  one-cycle pulse: returned word valid.
- `mem_to_if_inst`  in  32  returned instruction word.
- `stall_in`  in  1  downstream (RS/ROB/LSB) cannot accept an issue this cycle.
- `flush_in`  in  1  misprediction or exception redirect.
- `flush_PC`  in  32  new fetch PC, sampled when `flush_in` is high.
- `if_to_dc_ready`  out  1  head entry valid and consumed this cycle.
- `if_to_dc_PC`  out  32  PC of the head entry.
- `if_to_dc_inst`  out  32  raw instruction of the head entry.
- `if_to_dc_opType`  out  `OP_TYPE`  instruction class of the head entry.
- `if_to_dc_op`  out  `OPENUM_TYPE`  exact operation of the head entry.

## Operation
- **Reset values:**
  - `fetch_PC = RESET_PC`
  - FIFO empty: head = tail = count = 0
  - state `IDLE`
  - `if_to_mem_req = 0`, `if_to_mem_addr = 0`
  - `if_to_dc_ready = 0`, all `if_to_dc_*` outputs = 0
- **FSM, `IDLE`:**
  - If `count < QUEUE_DEPTH` and `!flush_in`: raise `req`, set `addr = fetch_PC`, go to `WAIT`.
  - The check reserves a slot for the in-flight word, so a push never finds the FIFO full.
- **FSM, `WAIT`:**
  - On `mem_to_if_valid`: push `{fetch_PC, inst, opType, op}`, drop `req`, go to `IDLE`.
  - After the push, `fetch_PC` becomes `fetch_PC + Jimm` if the opcode is JAL (1101111), otherwise `fetch_PC + 4`.
  - Jimm = sext{inst[31], inst[19:12], inst[20], inst[30:21], 0}.
- **FSM, `DISCARD`:**
  - Entered from `WAIT` on `flush_in` when no valid arrives that cycle.
  - Keeps `req` and `addr` unchanged until `mem_to_if_valid`, drops that word, then goes to `IDLE`.
- **Flush:**
  - Clears the FIFO and sets `fetch_PC = flush_PC`.
  - Forces `if_to_dc_ready` low that cycle.
  - Flush with a simultaneous `mem_to_if_valid` in `WAIT`: the word is dropped and the FSM goes to `IDLE`.
  - Flush in `DISCARD`: updates `fetch_PC` only.
- **Predecode, opType from opcode:**
  - 0110011 → `OP_RC`; 0010011 → `OP_RI`; 1100011 → `OP_BR`; 0000011 → `OP_LD`; 0100011 → `OP_ST`.
  - 0110111 → `OP_LUI`; 0010111 → `OP_AUIPC`; 1101111 → `OP_JAL`; 1100111 → `OP_JALR`.
  - Any other opcode → `OP_NONE`.
- **Predecode, op:** from opcode, funct3 and funct7[5] for all 37 RV32I instructions. An unknown encoding gives `OPENUM_NOP`.
- **Output:**
  - `if_to_dc_*` is driven combinationally from the FIFO head.
  - `if_to_dc_ready = !empty && !stall_in && rdy_in && !flush_in`.
  - When ready is high, the head pops at the clock edge.
  - When ready is low, the payload shows the head, or zeros if the FIFO is empty.
- **Arithmetic:** pointers are `log2(QUEUE_DEPTH)` bits and wrap naturally. Count is `log2+1` bits. PC arithmetic is 32-bit and wraps modulo 2^32.
- **Simultaneous push and pop:** count is unchanged; both pointers advance.

## Timing
- Request issue: `req` is asserted the cycle after entering `IDLE` with space available, so each word costs at least memory latency + 1 cycle.
- Valid arrives at edge N (FIFO empty, no stall): the word is pushed at N. `if_to_dc_ready` is high in cycle N+1 and the pop happens at edge N+1.
- Returned words are never bypassed straight to the decoder.
- `mem_to_if_valid` while `req` is low is ignored.
- `rdy_in` low freezes everything:
  - FSM, PC, FIFO and `req` all hold.
  - A `mem_to_if_valid` arriving then is lost. The memory controller is required to hold off valid while `rdy_in` is low.
- Asynchronous reset mid-request drops `req` immediately. Any stale valid that later arrives in `IDLE` is ignored.

## Structure
- The shared package `cpu_defs` holds:
  - `ADDR_TYPE`, `INST_TYPE`, `OP_TYPE` (4 bits) and `OPENUM_TYPE` (6 bits)
  - the `OP_*` class constants and the `OPENUM_*` enum
  - the `TRUE`/`FALSE` constants
- Sub-module `inst_predecode`: purely combinational `inst → {opType, op, is_jal, jimm}`. It is reused later by the branch predictor.
- The FIFO is inline: register arrays plus head, tail and count.

## Test plan
- **Reset:** `rst_in` low with `RESET_PC = 0` → `req = 0`, `if_to_dc_ready = 0`. Release reset → `req = 1`, `addr = 0` one cycle later.
- **Sequential fetch:** memory returns `addi x1,x0,5` (0x00500093) at PC 0 → next request `addr = 4`. Decoder sees `ready = 1`, PC 0, opType `OP_RI`, op `ADDI`, one cycle after valid.
- **JAL redirect:** the word at PC 8 is 0x0100006F (`jal x0,16`) → next `addr = 24`. The JAL itself is still queued with PC 8.
- **Backpressure:** `stall_in = 1` with four words returned → `count = 4` and `req` stays low. Drop the stall → four consecutive ready cycles in PC order.
- **Flush:** `flush_in = 1`, `flush_PC = 0x100` in `WAIT`; late valid three cycles later → that word is discarded, FIFO stays empty, next request `addr = 0x100`.
- **Flush with valid:** `flush_in` and `mem_to_if_valid` in the same cycle → no push, FSM `IDLE`, next `addr = flush_PC`.
